// File: rtl/axis_vid_pkg.sv
// Shared types and constants for the AXI4-Stream video pattern generator.
//   mode_e  : pattern select (solid, colour bars, ramp, checker)
//   state_e : generator FSM state
//   pixel_t : packed {c2, c1, c0} pixel, COMP_W bits per component
package axis_vid_pkg;

  localparam int unsigned COMP_W = 10;
  localparam int unsigned CNT_W  = 16;  // width of the x/y beat counters

  typedef enum logic [1:0] {
    ModeSolid   = 2'd0,
    ModeBars    = 2'd1,
    ModeRamp    = 2'd2,
    ModeChecker = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StGap    = 2'd2
  } state_e;

  typedef struct packed {
    logic [COMP_W-1:0] c2;
    logic [COMP_W-1:0] c1;
    logic [COMP_W-1:0] c0;
  } pixel_t;

endpackage

// File: rtl/video_pattern_pixel.sv
// Combinational pixel generator: maps beat coordinates, pattern mode and the
// solid colour to one pixel.
//   i_x, i_y  : pixel column / line
//   i_mode    : pattern select
//   i_color   : solid colour {c2,c1,c0}
//   o_pixel   : resulting pixel
module video_pattern_pixel
  import axis_vid_pkg::*;
#(
  parameter int unsigned BAR_SHIFT = 5
) (
  input  logic [CNT_W-1:0] i_x,
  input  logic [CNT_W-1:0] i_y,
  input  mode_e            i_mode,
  input  pixel_t           i_color,
  output pixel_t           o_pixel
);

  // x and y divided by the tile width; bit 0 is the tile parity, [2:0] the bar index
  logic [CNT_W-1:0] w_xs;
  logic [CNT_W-1:0] w_ys;
  logic             w_chk;

  assign w_xs  = i_x >> BAR_SHIFT;
  assign w_ys  = i_y >> BAR_SHIFT;
  assign w_chk = w_xs[0] ^ w_ys[0];

  always_comb begin
    o_pixel = '0;
    case (i_mode)
      ModeSolid: o_pixel = i_color;
      ModeBars: begin
        o_pixel.c0 = {COMP_W{w_xs[0]}};
        o_pixel.c1 = {COMP_W{w_xs[1]}};
        o_pixel.c2 = {COMP_W{w_xs[2]}};
      end
      ModeRamp: begin
        o_pixel.c0 = i_x[COMP_W-1:0];
        o_pixel.c1 = i_x[COMP_W-1:0];
        o_pixel.c2 = i_x[COMP_W-1:0];
      end
      ModeChecker: begin
        o_pixel.c0 = {COMP_W{w_chk}};
        o_pixel.c1 = {COMP_W{w_chk}};
        o_pixel.c2 = {COMP_W{w_chk}};
      end
      default: o_pixel = '0;
    endcase
  end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern generator. Emits frames of V_ACTIVE lines of
// H_ACTIVE beats, with H_GAP idle cycles after each line.
//   aclk, areset (async, active-high), aclken (clock enable)
//   enable_in     : keep generating frames while high (checked at frame start)
//   mode_in       : pattern, latched at each frame start
//   color_in      : solid colour, sampled per beat
//   m_axis_video_*: AXI4-Stream master (tuser = SOF, tlast = EOL)
//   busy_out      : FSM not idle
//   frame_count_out: completed frames, wrapping
module axis_video_pattern_gen
  import axis_vid_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 1920,
  parameter int unsigned V_ACTIVE  = 1080,
  parameter int unsigned H_GAP     = 4,
  parameter int unsigned BAR_SHIFT = 5
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        aclken,
  input  logic        enable_in,
  input  logic [1:0]  mode_in,
  input  logic [29:0] color_in,
  output logic [63:0] m_axis_video_tdata_out,
  output logic        m_axis_video_tvalid_out,
  input  logic        m_axis_video_tready_in,
  output logic        m_axis_video_tuser_out,
  output logic        m_axis_video_tlast_out,
  output logic        busy_out,
  output logic [15:0] frame_count_out
);

  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((H_GAP > 0) ? H_GAP - 1 : 0);
  localparam bit               HAS_GAP  = (H_GAP > 0);

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_x, w_x_d;
  logic [CNT_W-1:0] r_y, w_y_d;
  mode_e            r_mode, w_mode_d;
  logic [CNT_W-1:0] r_gap_cnt, w_gap_cnt_d;
  logic             r_eof, w_eof_d;  // the gap being served closes a frame
  logic [15:0]      r_frame_cnt, w_frame_cnt_d;
  logic             r_tvalid, w_tvalid_d;
  logic [63:0]      r_tdata;
  logic             r_tuser, r_tlast, r_busy;
  logic             w_xfer, w_load;
  pixel_t           w_pixel;

  assign w_xfer = r_tvalid & m_axis_video_tready_in & aclken;

  // The output registers always hold the beat at (r_x, r_y); a new beat is
  // computed from the next-state coordinates whenever w_load is set.
  always_comb begin
    w_state_d     = r_state;
    w_x_d         = r_x;
    w_y_d         = r_y;
    w_mode_d      = r_mode;
    w_gap_cnt_d   = r_gap_cnt;
    w_eof_d       = r_eof;
    w_frame_cnt_d = r_frame_cnt;
    w_tvalid_d    = r_tvalid;
    w_load        = 1'b0;
    if (aclken) begin
      case (r_state)
        StIdle: begin
          if (enable_in) begin
            w_state_d = StActive;
            w_x_d     = '0;
            w_y_d     = '0;
            w_mode_d  = mode_e'(mode_in);
            w_load    = 1'b1;
          end
        end
        StActive: begin
          if (w_xfer) begin
            if (r_x == X_LAST) begin
              w_x_d   = '0;
              w_eof_d = (r_y == Y_LAST);
              w_y_d   = w_eof_d ? '0 : r_y + 1'b1;
              if (w_eof_d) w_frame_cnt_d = r_frame_cnt + 1'b1;
              if (HAS_GAP) begin
                w_state_d   = StGap;
                w_gap_cnt_d = '0;
                w_tvalid_d  = 1'b0;
              end else if (w_eof_d && !enable_in) begin
                w_state_d  = StIdle;
                w_tvalid_d = 1'b0;
              end else begin
                w_load = 1'b1;
                if (w_eof_d) w_mode_d = mode_e'(mode_in);
              end
            end else begin
              w_x_d  = r_x + 1'b1;
              w_load = 1'b1;
            end
          end
        end
        StGap: begin
          if (r_gap_cnt == GAP_LAST) begin
            if (r_eof && !enable_in) begin
              w_state_d = StIdle;
            end else begin
              w_state_d = StActive;
              w_load    = 1'b1;
              if (r_eof) w_mode_d = mode_e'(mode_in);
            end
          end else begin
            w_gap_cnt_d = r_gap_cnt + 1'b1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
    if (w_load) w_tvalid_d = 1'b1;
  end

  video_pattern_pixel #(
    .BAR_SHIFT(BAR_SHIFT)
  ) u_pixel (
    .i_x    (w_x_d),
    .i_y    (w_y_d),
    .i_mode (w_mode_d),
    .i_color(pixel_t'(color_in)),
    .o_pixel(w_pixel)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state     <= StIdle;
      r_x         <= '0;
      r_y         <= '0;
      r_mode      <= ModeSolid;
      r_gap_cnt   <= '0;
      r_eof       <= 1'b0;
      r_frame_cnt <= '0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tuser     <= 1'b0;
      r_tlast     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_x         <= w_x_d;
      r_y         <= w_y_d;
      r_mode      <= w_mode_d;
      r_gap_cnt   <= w_gap_cnt_d;
      r_eof       <= w_eof_d;
      r_frame_cnt <= w_frame_cnt_d;
      r_tvalid    <= w_tvalid_d;
      r_busy      <= (w_state_d != StIdle);
      if (w_load) begin
        r_tdata <= {{(64 - 3 * COMP_W){1'b0}}, w_pixel};
        r_tuser <= (w_x_d == '0) && (w_y_d == '0);
        r_tlast <= (w_x_d == X_LAST);
      end
    end
  end

  assign m_axis_video_tdata_out  = r_tdata;
  assign m_axis_video_tvalid_out = r_tvalid;
  assign m_axis_video_tuser_out  = r_tuser;
  assign m_axis_video_tlast_out  = r_tlast;
  assign busy_out                = r_busy;
  assign frame_count_out         = r_frame_cnt;

endmodule
